// File: rtl/sb_tx_scheduler.sv
// Sideband TX scheduler: round-robin arbitration between the LT and AT requesters,
// then serializes the granted frame onto the SB byte lane with DLE stuffing and CRC control.
module sb_tx_scheduler (
  input  logic        sb_clk,
  input  logic        rst,
  input  logic        sb_disconnect,
  input  logic        lt_req,
  input  logic        lt_idx,
  input  logic        at_req,
  input  logic        at_is_cmd,
  input  logic [7:0]  at_addr,
  input  logic        at_rw,
  input  logic [1:0]  at_len,
  input  logic [23:0] at_data,
  input  logic [15:0] crc_in,
  input  logic        tx_ready,
  output logic [7:0]  sbtx,
  output logic        sbtx_valid,
  output logic        crc_en,
  output logic        lt_ack,
  output logic        at_ack,
  output logic        busy,
  output logic        tx_abort
);

  typedef enum logic [3:0] {
    IDLE, DLE_S, STX, ADDR, LEN, DATA, CRC_H, CRC_L, DLE_E, ETX, LSE, CLSE
  } state_t;

  typedef enum logic {GRANT_LT, GRANT_AT} grant_t;

  localparam logic [7:0] DLE     = 8'hFE;
  localparam logic [7:0] STX_CMD = 8'hA0;
  localparam logic [7:0] STX_RSP = 8'h20;
  localparam logic [7:0] ETX_SYM = 8'h40;

  state_t      state, nxt_state;
  grant_t      last_grant;
  logic        lat_lt, lat_idx, lat_cmd, lat_rw;
  logic [7:0]  lat_addr;
  logic [1:0]  lat_len;
  logic [23:0] lat_data;
  logic [1:0]  cnt, nxt_cnt;
  logic        stuff;
  logic [15:0] crc_q;
  logic [7:0]  nxt_sym;
  logic        nxt_crc_en;

  logic        accept, grant_lt, stuff_now, last_crc_sym;
  logic [7:0]  lse_byte, crc_hi;

  assign accept   = sbtx_valid & tx_ready;
  assign lse_byte = {4'b0000, lat_idx, 3'b010};
  assign grant_lt = lt_req & (~at_req | (last_grant == GRANT_AT));

  // An FE body/CRC byte is repeated once; the repeat is not fed to the CRC.
  assign stuff_now = (state inside {ADDR, LEN, DATA, CRC_H, CRC_L}) && (sbtx == DLE) && !stuff;

  assign last_crc_sym = crc_en && (((state == LEN) && (lat_len == 2'd0)) ||
                                   ((state == DATA) && (cnt == lat_len - 2'd1)));

  // The CRC is captured on the same edge that may already move to CRC_H.
  assign crc_hi = last_crc_sym ? crc_in[15:8] : crc_q[15:8];

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    case (state)
      DLE_S: nxt_state = lat_lt ? LSE : STX;
      LSE:   nxt_state = CLSE;
      STX:   nxt_state = ADDR;
      ADDR:  nxt_state = LEN;
      LEN: begin
        nxt_cnt   = 2'd0;
        nxt_state = (lat_len == 2'd0) ? CRC_H : DATA;
      end
      DATA: begin
        if (cnt == lat_len - 2'd1) nxt_state = CRC_H;
        else                       nxt_cnt   = cnt + 2'd1;
      end
      CRC_H: nxt_state = CRC_L;
      CRC_L: nxt_state = DLE_E;
      DLE_E: nxt_state = ETX;
      default: nxt_state = IDLE;
    endcase

    nxt_sym = 8'h00;
    case (nxt_state)
      DLE_S:   nxt_sym = DLE;
      STX:     nxt_sym = lat_cmd ? STX_CMD : STX_RSP;
      ADDR:    nxt_sym = lat_addr;
      LEN:     nxt_sym = {lat_rw, 5'b00000, lat_len};
      DATA:    nxt_sym = lat_data[{nxt_cnt, 3'b000} +: 8];
      CRC_H:   nxt_sym = crc_hi;
      CRC_L:   nxt_sym = crc_q[7:0];
      DLE_E:   nxt_sym = DLE;
      ETX:     nxt_sym = ETX_SYM;
      LSE:     nxt_sym = lse_byte;
      CLSE:    nxt_sym = ~lse_byte;
      default: nxt_sym = 8'h00;
    endcase
    nxt_crc_en = nxt_state inside {STX, ADDR, LEN, DATA};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees pre-edge values regardless of statement order.
  always_ff @(posedge sb_clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GRANT_AT;
      lat_lt     <= 1'b0;
      lat_idx    <= 1'b0;
      lat_cmd    <= 1'b0;
      lat_rw     <= 1'b0;
      lat_addr   <= 8'h00;
      lat_len    <= 2'd0;
      lat_data   <= 24'h0;
      cnt        <= 2'd0;
      stuff      <= 1'b0;
      crc_q      <= 16'h0;
      sbtx       <= 8'h00;
      sbtx_valid <= 1'b0;
      crc_en     <= 1'b0;
      lt_ack     <= 1'b0;
      at_ack     <= 1'b0;
      busy       <= 1'b0;
      tx_abort   <= 1'b0;
    end else begin
      lt_ack   <= 1'b0;
      at_ack   <= 1'b0;
      tx_abort <= 1'b0;
      if (state != IDLE && sb_disconnect) begin
        state      <= IDLE;
        sbtx       <= 8'h00;
        sbtx_valid <= 1'b0;
        crc_en     <= 1'b0;
        busy       <= 1'b0;
        stuff      <= 1'b0;
        cnt        <= 2'd0;
        tx_abort   <= 1'b1;
      end else if (state == IDLE) begin
        if (!sb_disconnect && (lt_req || at_req)) begin
          lat_lt     <= grant_lt;
          lat_idx    <= lt_idx;
          lat_cmd    <= at_is_cmd;
          lat_rw     <= at_rw;
          lat_addr   <= at_addr;
          lat_len    <= at_len;
          lat_data   <= at_data;
          last_grant <= grant_lt ? GRANT_LT : GRANT_AT;
          lt_ack     <= grant_lt;
          at_ack     <= ~grant_lt;
          state      <= DLE_S;
          sbtx       <= DLE;
          sbtx_valid <= 1'b1;
          crc_en     <= 1'b0;
          busy       <= 1'b1;
          cnt        <= 2'd0;
          stuff      <= 1'b0;
        end
      end else if (accept) begin
        if (last_crc_sym) crc_q <= crc_in;
        if (stuff_now) begin
          stuff  <= 1'b1;
          crc_en <= 1'b0;
        end else begin
          stuff      <= 1'b0;
          state      <= nxt_state;
          cnt        <= nxt_cnt;
          sbtx       <= nxt_sym;
          crc_en     <= nxt_crc_en;
          sbtx_valid <= (nxt_state != IDLE);
          busy       <= (nxt_state != IDLE);
        end
      end
    end
  end

endmodule

// File: tb/tb_sb_tx_scheduler.sv
// Directed testbench for sb_tx_scheduler: frame contents, arbitration, back-pressure,
// disconnect abort and mid-frame reset, each with hand-computed expected symbols.
module tb_sb_tx_scheduler;

  logic        sb_clk = 1'b0;
  logic        rst = 1'b1;
  logic        sb_disconnect = 1'b0;
  logic        lt_req = 1'b0;
  logic        lt_idx = 1'b0;
  logic        at_req = 1'b0;
  logic        at_is_cmd = 1'b0;
  logic [7:0]  at_addr = 8'h00;
  logic        at_rw = 1'b0;
  logic [1:0]  at_len = 2'd0;
  logic [23:0] at_data = 24'h0;
  logic [15:0] crc_in = 16'h0;
  logic        tx_ready = 1'b1;
  logic [7:0]  sbtx;
  logic        sbtx_valid, crc_en, lt_ack, at_ack, busy, tx_abort;

  int checks = 0;
  int errors = 0;

  logic [7:0] got_sym [16];
  logic       got_crc [16];
  int         got_n;
  int         hold_seen, hold_bad;
  bit         timed_out;

  sb_tx_scheduler dut (
    .sb_clk(sb_clk), .rst(rst), .sb_disconnect(sb_disconnect),
    .lt_req(lt_req), .lt_idx(lt_idx), .at_req(at_req), .at_is_cmd(at_is_cmd),
    .at_addr(at_addr), .at_rw(at_rw), .at_len(at_len), .at_data(at_data),
    .crc_in(crc_in), .tx_ready(tx_ready), .sbtx(sbtx), .sbtx_valid(sbtx_valid),
    .crc_en(crc_en), .lt_ack(lt_ack), .at_ack(at_ack), .busy(busy), .tx_abort(tx_abort)
  );

  always #5 sb_clk = ~sb_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (time %0t, required < 500000)", $time);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge sb_clk);
    #1;
  endtask

  // Records accepted symbols from the current sample point until sbtx_valid drops.
  // Optionally stalls the lane at symbol hold_idx, or returns while symbol stop_idx is shown.
  task automatic collect(input int hold_idx, input int hold_cycles, input int stop_idx);
    int holds = 0;
    bit started = 0;
    logic [7:0] held_sym = 8'h00;
    logic held_crc = 1'b0;
    got_n = 0; hold_seen = 0; hold_bad = 0; timed_out = 0;
    for (int cyc = 0; cyc < 64; cyc++) begin
      if (sbtx_valid === 1'b1) begin
        started = 1;
        if (got_n == stop_idx) return;
        if (got_n == hold_idx && holds < hold_cycles) begin
          if (holds == 0) begin
            held_sym = sbtx;
            held_crc = crc_en;
          end else if (sbtx !== held_sym || crc_en !== held_crc) begin
            hold_bad++;
          end
          holds++;
          hold_seen = holds;
          tx_ready = 1'b0;
        end else begin
          tx_ready = 1'b1;
          if (got_n < 16) begin
            got_sym[got_n] = sbtx;
            got_crc[got_n] = crc_en;
          end
          got_n++;
        end
      end else if (started) begin
        tx_ready = 1'b1;
        return;
      end
      step();
    end
    timed_out = 1;
    tx_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({sbtx, sbtx_valid, crc_en, lt_ack, at_ack, busy, tx_abort} !== 14'h0) begin
      errors++;
      $display("FAIL reset_outputs: got sbtx=%h v=%b crc=%b lt_ack=%b at_ack=%b busy=%b abort=%b, required all 0",
               sbtx, sbtx_valid, crc_en, lt_ack, at_ack, busy, tx_abort);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_lt1 [3] = '{8'hFE, 8'h02, 8'hFD};
    logic [7:0] exp_at  [8] = '{8'hFE, 8'h20, 8'h07, 8'h00, 8'h11, 8'h11, 8'hFE, 8'h40};
    logic [7:0] exp_lt2 [3] = '{8'hFE, 8'h0A, 8'hF5};
    at_is_cmd = 1'b0; at_addr = 8'h07; at_rw = 1'b0; at_len = 2'd0; crc_in = 16'h1111;
    lt_idx = 1'b0; lt_req = 1'b1; at_req = 1'b1;
    step();
    checks++;
    if ({lt_ack, at_ack} !== 2'b10) begin
      errors++;
      $display("FAIL rr_first_tie: got lt_ack=%b at_ack=%b, required 1 0", lt_ack, at_ack);
    end
    lt_req = 1'b0;
    collect(-1, 0, -1);
    checks++;
    if (got_n != 3 || timed_out) begin
      errors++;
      $display("FAIL rr_lt1_len: got %0d symbols (timeout=%0b), required 3", got_n, timed_out);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_sym[i] !== exp_lt1[i]) begin
          errors++;
          $display("FAIL rr_lt1_sym%0d: got %h, required %h", i, got_sym[i], exp_lt1[i]);
        end
      end
    end
    checks++;
    if (sbtx_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rr_gap1: got valid=%b busy=%b, required 0 0", sbtx_valid, busy);
    end
    lt_idx = 1'b1; lt_req = 1'b1;
    step();
    checks++;
    if ({lt_ack, at_ack} !== 2'b01) begin
      errors++;
      $display("FAIL rr_second: got lt_ack=%b at_ack=%b, required 0 1", lt_ack, at_ack);
    end
    at_req = 1'b0;
    collect(-1, 0, -1);
    checks++;
    if (got_n != 8 || timed_out) begin
      errors++;
      $display("FAIL rr_at_len: got %0d symbols (timeout=%0b), required 8", got_n, timed_out);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (got_sym[i] !== exp_at[i]) begin
          errors++;
          $display("FAIL rr_at_sym%0d: got %h, required %h", i, got_sym[i], exp_at[i]);
        end
      end
    end
    checks++;
    if (sbtx_valid !== 1'b0) begin
      errors++;
      $display("FAIL rr_gap2: got valid=%b, required 0", sbtx_valid);
    end
    step();
    checks++;
    if ({lt_ack, at_ack, sbtx} !== {2'b10, 8'hFE}) begin
      errors++;
      $display("FAIL rr_third: got lt_ack=%b at_ack=%b sbtx=%h, required 1 0 fe", lt_ack, at_ack, sbtx);
    end
    lt_req = 1'b0;
    collect(-1, 0, -1);
    checks++;
    if (got_n != 3 || timed_out) begin
      errors++;
      $display("FAIL rr_lt2_len: got %0d symbols, required 3", got_n);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_sym[i] !== exp_lt2[i]) begin
          errors++;
          $display("FAIL rr_lt2_sym%0d: got %h, required %h", i, got_sym[i], exp_lt2[i]);
        end
      end
    end
    step();
  endtask

  task automatic test_lt_frame();
    logic [7:0] exp_sym [3] = '{8'hFE, 8'h02, 8'hFD};
    lt_idx = 1'b0; lt_req = 1'b1;
    step();
    checks++;
    if ({lt_ack, at_ack, sbtx_valid, sbtx, busy} !== {3'b101, 8'hFE, 1'b1}) begin
      errors++;
      $display("FAIL lt_start: got lt_ack=%b at_ack=%b v=%b sbtx=%h busy=%b, required 1 0 1 fe 1",
               lt_ack, at_ack, sbtx_valid, sbtx, busy);
    end
    lt_req = 1'b0;
    collect(-1, 0, -1);
    checks++;
    if (got_n != 3 || timed_out) begin
      errors++;
      $display("FAIL lt_len: got %0d symbols, required 3", got_n);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_sym[i] !== exp_sym[i] || got_crc[i] !== 1'b0) begin
          errors++;
          $display("FAIL lt_sym%0d: got %h crc_en=%b, required %h crc_en=0",
                   i, got_sym[i], got_crc[i], exp_sym[i]);
        end
      end
    end
    step();
  endtask

  task automatic test_at_stuffed();
    logic [7:0] exp_sym [12] = '{8'hFE, 8'hA0, 8'h12, 8'h83, 8'h56, 8'h34,
                                 8'hFE, 8'hFE, 8'hAB, 8'hCD, 8'hFE, 8'h40};
    logic       exp_crc [12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    at_is_cmd = 1'b1; at_addr = 8'h12; at_rw = 1'b1; at_len = 2'd3;
    at_data = 24'hFE3456; crc_in = 16'hABCD; at_req = 1'b1;
    step();
    checks++;
    if ({lt_ack, at_ack, sbtx} !== {2'b01, 8'hFE}) begin
      errors++;
      $display("FAIL at_start: got lt_ack=%b at_ack=%b sbtx=%h, required 0 1 fe", lt_ack, at_ack, sbtx);
    end
    at_req = 1'b0;
    collect(-1, 0, -1);
    checks++;
    if (got_n != 12 || timed_out) begin
      errors++;
      $display("FAIL at_len: got %0d symbols, required 12", got_n);
    end else begin
      for (int i = 0; i < 12; i++) begin
        checks++;
        if (got_sym[i] !== exp_sym[i] || got_crc[i] !== exp_crc[i]) begin
          errors++;
          $display("FAIL at_sym%0d: got %h crc_en=%b, required %h crc_en=%b",
                   i, got_sym[i], got_crc[i], exp_sym[i], exp_crc[i]);
        end
      end
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_sym [9] = '{8'hFE, 8'hA0, 8'h05, 8'h01, 8'h11, 8'h12, 8'h34, 8'hFE, 8'h40};
    logic       exp_crc [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    at_is_cmd = 1'b1; at_addr = 8'h05; at_rw = 1'b0; at_len = 2'd1;
    at_data = 24'h000011; crc_in = 16'h1234; at_req = 1'b1;
    step();
    at_req = 1'b0;
    collect(3, 4, -1);
    checks++;
    if (hold_seen != 4 || hold_bad != 0) begin
      errors++;
      $display("FAIL bp_hold: got %0d stalled cycles with %0d changes, required 4 with 0", hold_seen, hold_bad);
    end
    checks++;
    if (got_n != 9 || timed_out) begin
      errors++;
      $display("FAIL bp_len: got %0d symbols, required 9", got_n);
    end else begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (got_sym[i] !== exp_sym[i] || got_crc[i] !== exp_crc[i]) begin
          errors++;
          $display("FAIL bp_sym%0d: got %h crc_en=%b, required %h crc_en=%b",
                   i, got_sym[i], got_crc[i], exp_sym[i], exp_crc[i]);
        end
      end
    end
    step();
  endtask

  task automatic test_disconnect();
    at_is_cmd = 1'b1; at_addr = 8'h44; at_rw = 1'b1; at_len = 2'd3;
    at_data = 24'h002211; crc_in = 16'h0F0F; at_req = 1'b1;
    step();
    at_req = 1'b0;
    collect(-1, 0, 5);
    checks++;
    if (got_n != 5 || sbtx !== 8'h22) begin
      errors++;
      $display("FAIL dc_reach_data: got %0d symbols, sbtx=%h, required 5 and 22", got_n, sbtx);
    end
    sb_disconnect = 1'b1; lt_req = 1'b1; at_req = 1'b1;
    step();
    checks++;
    if ({sbtx_valid, crc_en, busy, tx_abort} !== 4'b0001) begin
      errors++;
      $display("FAIL dc_abort: got v=%b crc=%b busy=%b abort=%b, required 0 0 0 1",
               sbtx_valid, crc_en, busy, tx_abort);
    end
    step();
    checks++;
    if ({tx_abort, lt_ack, at_ack, sbtx_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL dc_ignore1: got abort=%b lt_ack=%b at_ack=%b v=%b, required 0 0 0 0",
               tx_abort, lt_ack, at_ack, sbtx_valid);
    end
    step();
    checks++;
    if ({lt_ack, at_ack, busy} !== 3'b000) begin
      errors++;
      $display("FAIL dc_ignore2: got lt_ack=%b at_ack=%b busy=%b, required 0 0 0", lt_ack, at_ack, busy);
    end
    sb_disconnect = 1'b0;
    step();
    checks++;
    if ({lt_ack, at_ack, sbtx} !== {2'b10, 8'hFE}) begin
      errors++;
      $display("FAIL dc_resume: got lt_ack=%b at_ack=%b sbtx=%h, required 1 0 fe", lt_ack, at_ack, sbtx);
    end
    lt_req = 1'b0; at_req = 1'b0;
    collect(-1, 0, -1);
    step();
  endtask

  task automatic test_reset_mid_frame();
    at_is_cmd = 1'b0; at_addr = 8'h33; at_rw = 1'b0; at_len = 2'd0;
    crc_in = 16'h5678; at_req = 1'b1;
    step();
    at_req = 1'b0;
    collect(-1, 0, 4);
    checks++;
    if (sbtx !== 8'h56) begin
      errors++;
      $display("FAIL rm_reach_crc_h: got sbtx=%h, required 56", sbtx);
    end
    rst = 1'b1; at_req = 1'b1;
    step();
    checks++;
    if ({sbtx, sbtx_valid, crc_en, lt_ack, at_ack, busy, tx_abort} !== 14'h0) begin
      errors++;
      $display("FAIL rm_outputs: got sbtx=%h v=%b crc=%b lt_ack=%b at_ack=%b busy=%b abort=%b, required all 0",
               sbtx, sbtx_valid, crc_en, lt_ack, at_ack, busy, tx_abort);
    end
    rst = 1'b0;
    step();
    checks++;
    if ({at_ack, sbtx_valid, sbtx} !== {2'b11, 8'hFE}) begin
      errors++;
      $display("FAIL rm_regrant: got at_ack=%b v=%b sbtx=%h, required 1 1 fe", at_ack, sbtx_valid, sbtx);
    end
    at_req = 1'b0;
    collect(-1, 0, -1);
    checks++;
    if (got_n != 8 || got_sym[4] !== 8'h56 || got_sym[5] !== 8'h78) begin
      errors++;
      $display("FAIL rm_frame: got %0d symbols crc %h%h, required 8 symbols crc 5678",
               got_n, got_sym[4], got_sym[5]);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_lt_frame();
    test_at_stuffed();
    test_backpressure();
    test_disconnect();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
